// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - shared constants for the CHIP-8 RAM arbiter
package chip8_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;

  // Interpreter and font area; writes below this are blocked when write protection is built in
  localparam logic [ADDR_W-1:0] WP_LIMIT = 12'h200;

  localparam int REQ_CPU_FETCH = 0;
  localparam int REQ_CPU_DATA  = 1;
  localparam int REQ_DISPLAY   = 2;

endpackage

// File: rtl/chip8_rr_picker.sv
// rtl/chip8_rr_picker.sv - combinational round-robin one-hot picker
module chip8_rr_picker #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  int j;

  // Walk the requesters starting at ptr, wrapping once; the first set bit wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!valid && req[j]) begin
        gnt[j] = 1'b1;
        idx    = PTR_W'(j);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chip8_ram_arbiter.sv
// rtl/chip8_ram_arbiter.sv - round-robin arbiter for the shared CHIP-8 RAM port
// Optional write protection of the low 512 bytes: define CHIP8_RAM_WP_EN.
module chip8_ram_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = chip8_pkg::ADDR_W,
  parameter int DATA_W  = chip8_pkg::DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_d,
  output logic                      mem_we,
  input  logic [DATA_W-1:0]         mem_q,
  output logic                      wp_err
);

  import chip8_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   win;
  logic               any_gnt;
  logic [NUM_REQ-1:0] rd_tag;
  logic               we_win;
  logic [ADDR_W-1:0]  addr_win;
  logic [DATA_W-1:0]  d_win;
  logic               wp_blk;

  chip8_rr_picker #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req   (req),
    .ptr   (rr_ptr),
    .gnt   (gnt),
    .idx   (win),
    .valid (any_gnt)
  );

  // Only the winner's lane is ever selected, so idle lanes cannot leak onto the RAM bus.
  always_comb begin
    we_win   = 1'b0;
    addr_win = '0;
    d_win    = '0;
    if (any_gnt) begin
      we_win   = req_we[win];
      addr_win = req_addr[int'(win)*ADDR_W +: ADDR_W];
      d_win    = req_wdata[int'(win)*DATA_W +: DATA_W];
    end
  end

`ifdef CHIP8_RAM_WP_EN
  assign wp_blk = we_win && (addr_win < WP_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wp_err <= 1'b0;
    else        wp_err <= wp_blk;
  end
`else
  assign wp_blk = 1'b0;
  assign wp_err = 1'b0;
`endif

  assign mem_addr = addr_win;
  assign mem_d    = d_win;
  assign mem_we   = we_win && !wp_blk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      rd_tag <= '0;
    end else begin
      if (any_gnt) rr_ptr <= (int'(win) == NUM_REQ-1) ? '0 : win + 1'b1;
      rd_tag <= (any_gnt && !we_win) ? gnt : '0;
    end
  end

  // RAM output is already registered, so read data passes straight through.
  assign rvalid = rd_tag;
  assign rdata  = mem_q;

endmodule

// File: tb/tb_chip8_ram_arbiter.sv
// tb/tb_chip8_ram_arbiter.sv - self-checking bench for chip8_ram_arbiter
module tb_chip8_ram_arbiter;

  localparam int N = 3;
`ifdef CHIP8_RAM_WP_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req, req_we, gnt, rvalid;
  logic [N*12-1:0] req_addr;
  logic [N*8-1:0]  req_wdata;
  logic [7:0]      rdata, mem_d, mem_q;
  logic [11:0]     mem_addr;
  logic            mem_we, wp_err;

  chip8_ram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_addr(mem_addr), .mem_d(mem_d), .mem_we(mem_we), .mem_q(mem_q), .wp_err(wp_err)
  );

  // RAM with registered read
  logic [7:0] ram [4096];
  logic [7:0] ram_q;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_d;
    ram_q <= ram[mem_addr];
  end
  assign mem_q = ram_q;

  // Reference model state
  logic [7:0]  ref_mem [4096];
  int          ptr;
  logic [N-1:0] l_req, l_we;
  logic [11:0] l_addr [N];
  logic [7:0]  l_wdata [N];
  int          wait_cnt [N];
  logic [N-1:0] last_gnt, last_rv;
  logic [7:0]  last_rd;
  logic        last_wp;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (l_req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic cycle();
    int w;
    logic [N-1:0] eg, nrv;
    logic [7:0]   nrd, e_d;
    logic [11:0]  e_addr;
    logic         e_we, nwp;
    for (int i = 0; i < N; i++) begin
      req[i] = l_req[i];
      req_we[i] = l_we[i];
      req_addr[i*12 +: 12] = l_addr[i];
      req_wdata[i*8 +: 8] = l_wdata[i];
    end
    #1;
    w = pick();
    eg = '0; nrv = '0; nrd = '0; e_d = '0; e_addr = '0; e_we = 1'b0; nwp = 1'b0;
    if (w >= 0) begin
      eg[w] = 1'b1;
      e_addr = l_addr[w];
      e_d = l_wdata[w];
      if (l_we[w]) begin
        if (WP_ON && l_addr[w] < 12'h200) nwp = 1'b1;
        else begin
          e_we = 1'b1;
          ref_mem[l_addr[w]] = l_wdata[w];
        end
      end else begin
        nrv[w] = 1'b1;
        nrd = ref_mem[l_addr[w]];
      end
      ptr = (w + 1) % N;
    end
    check("gnt", gnt, eg);
    check("mem_we", mem_we, e_we);
    check("mem_addr", mem_addr, e_addr);
    check("mem_d", mem_d, e_d);
    last_gnt = gnt;
    @(posedge clk);
    #1;
    check("rvalid", rvalid, nrv);
    if (nrv != '0) check("rdata", rdata, nrd);
    check("wp_err", wp_err, nwp);
    last_rv = rvalid;
    last_rd = rdata;
    last_wp = wp_err;
  endtask

  task automatic set_lane(input int i, input logic r, input logic we, input logic [11:0] a, input logic [7:0] d);
    l_req[i] = r; l_we[i] = we; l_addr[i] = a; l_wdata[i] = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) set_lane(i, 1'b0, 1'b0, 12'h000, 8'h00);
  endtask

  initial begin
    int fair_seq [6];
    fair_seq = '{1, 2, 4, 1, 2, 4};
    for (int a = 0; a < 4096; a++) begin
      ram[a] = 8'(a) ^ 8'h5A;
      ref_mem[a] = 8'(a) ^ 8'h5A;
    end
    ram[12'h050] = 8'hF0;
    ref_mem[12'h050] = 8'hF0;
    ptr = 0;
    idle_all();
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rvalid", rvalid, 0);
    check("rst_wp_err", wp_err, 0);
    check("rst_gnt", gnt, 0);
    check("rst_mem_we", mem_we, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single read from the display lane
    set_lane(2, 1'b1, 1'b0, 12'h050, 8'h00);
    cycle();
    check("single_gnt", last_gnt, 3'b100);
    check("single_rv", last_rv, 3'b100);
    check("single_rd", last_rd, 8'hF0);
    idle_all();

    // reset while a read is outstanding
    set_lane(0, 1'b1, 1'b0, 12'h123, 8'h00);
    cycle();
    idle_all();
    rst_n = 1'b0;
    #1;
    check("rst_mid_rv", rvalid, 0);
    ptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check("rst_after_rv", last_rv, 0);

    // fairness with all three lanes reading continuously
    for (int i = 0; i < N; i++) set_lane(i, 1'b1, 1'b0, 12'h050 + 12'(i), 8'h00);
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("fair_gnt", last_gnt, fair_seq[k]);
      if (k > 0) check("fair_rv", last_rv, fair_seq[k]);
    end
    idle_all();

    // write then read same address
    set_lane(1, 1'b1, 1'b1, 12'h300, 8'hA5);
    cycle();
    set_lane(1, 1'b1, 1'b0, 12'h300, 8'h00);
    cycle();
    check("wr_rd_rv", last_rv, 3'b010);
    check("wr_rd_data", last_rd, 8'hA5);
    idle_all();

    // pointer holds across idle cycles
    set_lane(1, 1'b1, 1'b0, 12'h010, 8'h00);
    cycle();
    idle_all();
    repeat (3) cycle();
    set_lane(0, 1'b1, 1'b0, 12'h011, 8'h00);
    set_lane(1, 1'b1, 1'b0, 12'h012, 8'h00);
    cycle();
    check("idle_gap_gnt", last_gnt, 3'b001);
    idle_all();
    cycle();

    // write into the protected region
    set_lane(1, 1'b1, 1'b1, 12'h1FF, 8'h00);
    cycle();
    check("wp_gnt", last_gnt, 3'b010);
    check("wp_pulse", last_wp, WP_ON);
    set_lane(1, 1'b1, 1'b0, 12'h1FF, 8'h00);
    cycle();
    check("wp_readback", last_rd, WP_ON ? (8'hFF ^ 8'h5A) : 8'h00);
    set_lane(1, 1'b1, 1'b1, 12'h200, 8'h3C);
    cycle();
    check("wp_ok_pulse", last_wp, 0);
    idle_all();

    // randomized traffic with requests held until granted
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!l_req[i]) begin
          logic [11:0] a;
          case ($urandom % 4)
            0: a = 12'h050;
            1: a = 12'h1F0 + 12'($urandom % 32);
            2: a = 12'h300 + 12'($urandom % 8);
            default: a = 12'($urandom);
          endcase
          set_lane(i, ($urandom % 2) == 1, ($urandom % 3) == 0, a, 8'($urandom));
          wait_cnt[i] = 0;
        end
      end
      cycle();
      for (int i = 0; i < N; i++) begin
        if (l_req[i]) begin
          wait_cnt[i]++;
          if (last_gnt[i]) begin
            check("starve_bound", 32'(wait_cnt[i] <= N), 1);
            l_req[i] = 1'b0;
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/chip8_ram_arbiter.md
Name: chip8_ram_arbiter

Overview:
Shares the single-port-per-cycle 4096x8 CHIP-8 RAM (12-bit address, 8-bit data, registered read, 1-cycle latency) among NUM_REQ requesters: CPU fetch, CPU data and display sprite reader. Fair round-robin arbitration at one transaction per cycle. Drives the RAM's shared read/write address, write data and write enable. Returns read data to the requester that issued the read, tagged by rvalid.

Parameters:
NUM_REQ, 3, number of requesters (2..8); index 0 wins ties after reset
ADDR_W, 12, RAM address width
DATA_W, 8, RAM data width

Ports:
clk  in  1  system clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester request, held until granted
req_we  in  NUM_REQ  1 = write, 0 = read; per requester
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
gnt  out  NUM_REQ  one-hot (or zero) grant, combinational, same cycle as request
rvalid  out  NUM_REQ  one-hot read-data-valid, registered
rdata  out  DATA_W  read data, meaningful only where rvalid set
mem_addr  out  ADDR_W  to RAM read_address and write_address
mem_d  out  DATA_W  to RAM d
mem_we  out  1  to RAM we
mem_q  in  DATA_W  from RAM q
wp_err  out  1  write-protect violation pulse (0 when RAM_WP_EN undefined)

Behaviour:
- Reset (async assert, sync-released use): rr_ptr=0, rvalid=0, rd_tag=0, wp_err=0. gnt/mem_* combinational, evaluate to 0 when req=0. Pending read at reset is dropped; no rvalid after release.
- Handshake: requester asserts req with stable we/addr/wdata; transfer occurs in the cycle gnt[i]=1. Requester may deassert or present the next request the following cycle. gnt never asserted without req.
- Arbitration: search starts at rr_ptr, wraps modulo NUM_REQ; first set req bit wins. On any grant to i, rr_ptr <= (i+1) mod NUM_REQ. No grant: rr_ptr holds.
- Datapath: mem_addr/mem_d/mem_we = winner's addr/wdata/we (mem_we also gated by protection, below). No winner: mem_addr=0, mem_d=0, mem_we=0.
- Reads: RAM returns q next cycle. Register rd_tag = one-hot of granted reader. Cycle N+1: rvalid = rd_tag, rdata = mem_q (combinational pass-through of registered RAM output). Writes produce no rvalid.
- Throughput: one grant per cycle, back-to-back reads from the same or different requesters allowed; rvalid may assert every cycle.
- Ordering: write at cycle N followed by read of same address at N+1 returns new data. Single shared port, so no same-cycle read/write collision.
- Starvation bound: any held request granted within NUM_REQ cycles.
- Only requester i's own inputs affect its grant; X on non-requesting lanes must not propagate.

Optional Feature:
CHIP8_RAM_WP_EN: when defined, writes with addr < 12'h200 (interpreter/font area) are granted (gnt pulses, pointer advances) but mem_we forced 0; wp_err pulses high for 1 cycle, registered (cycle after grant). When undefined: all writes pass, wp_err tied 0.

Decomposition:
- Package chip8_pkg: ADDR_W=12, DATA_W=8, WP_LIMIT=12'h200, requester indices REQ_CPU_FETCH=0, REQ_CPU_DATA=1, REQ_DISPLAY=2.
- Sub-module chip8_rr_picker: combinational round-robin one-hot picker (req, rr_ptr -> gnt one-hot, winner index). Arbiter holds pointer, tag, mux, protection.

Test Plan:
- Reset: assert rst_n=0 mid-read (rd_tag set) -> rvalid=0 immediately, stays 0 after release; next grant with req=3'b111 goes to 0.
- Single read: req[2] read addr 12'h050 (font byte 8'hF0) -> gnt=3'b100 same cycle, rvalid=3'b100 and rdata=8'hF0 next cycle.
- Fairness: req=3'b111 held 6 cycles, all reads -> gnt sequence 001,010,100,001,010,100; rvalid follows one cycle later.
- Write-then-read: req[1] write 12'h300<=8'hA5, next cycle read 12'h300 -> rvalid[1]=1, rdata=8'hA5.
- Idle gap: req=0 for 3 cycles after grant to 1 -> pointer holds; next req=3'b011 grants 0 before 1? no: grants 0 only if ptr=2->0; expect gnt=3'b001 (ptr=2, wraps to 0).
- CHIP8_RAM_WP_EN: write 12'h1FF<=8'h00 -> gnt pulses, mem_we=0, wp_err=1 next cycle, readback of 12'h1FF unchanged; write 12'h200 -> mem_we=1, wp_err=0.
